// File: rtl/seq_divider_n_if.sv
// Start/done handshake bundle for seq_divider_n.
// SEQ_DIV_SIGNED_EN adds the signed_mode request bit.
interface seq_divider_n_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
  logic             signed_mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
`ifdef SEQ_DIV_SIGNED_EN
    output signed_mode,
`endif
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  signed_mode,
`endif
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_n.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Optional two's-complement mode behind SEQ_DIV_SIGNED_EN.
module seq_divider_n #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_divider_n_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quo_o;
  logic [WIDTH-1:0] r_rem_o;
  logic             r_dbz_o;

  logic             w_sm;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_accept;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_step;

`ifdef SEQ_DIV_SIGNED_EN
  assign w_sm = bus.signed_mode;
`else
  assign w_sm = 1'b0;
`endif

  // The core always sees magnitudes; signs are reapplied when results are written.
  assign w_dvd_neg = w_sm & bus.dividend[WIDTH-1];
  assign w_dsr_neg = w_sm & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign w_dsr_mag = w_dsr_neg ? (~bus.divisor + 1'b1) : bus.divisor;

  assign w_accept = (r_state != S_CALC) && bus.start;
  assign w_last   = (r_cnt == CW'(WIDTH));
  assign w_finish = (r_state == S_CALC) && (w_last || r_dbz);

  assign w_trial    = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dsr});
  assign w_diff     = w_trial - {1'b0, r_dsr};
  assign w_rem_step = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Divide-by-zero still spends one CALC cycle so DONE lands one edge after acceptance.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_CALC;
      S_CALC:  if (w_last || r_dbz) w_state_next = S_DONE;
      S_DONE:  w_state_next = bus.start ? S_CALC : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo_o <= '0;
      r_rem_o <= '0;
      r_dbz_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_dvd   <= w_dvd_mag;
        r_dsr   <= w_dsr_mag;
        r_rem   <= '0;
        r_dbz   <= (bus.divisor == '0);
        r_neg_q <= w_dvd_neg ^ w_dsr_neg;
        r_neg_r <= w_dvd_neg;
      end else if ((r_state == S_CALC) && !w_last && !r_dbz) begin
        // r_dvd doubles as the quotient shift register.
        r_rem <= w_rem_step;
        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_finish) begin
        if (r_dbz) begin
          r_quo_o <= '1;
          r_rem_o <= r_neg_r ? (~r_dvd + 1'b1) : r_dvd;
          r_dbz_o <= 1'b1;
        end else begin
          r_quo_o <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
          r_rem_o <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
          r_dbz_o <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (r_state == S_CALC);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quo_o;
  assign bus.remainder   = r_rem_o;
  assign bus.div_by_zero = r_dbz_o;
endmodule
